wah_svf_sweep: RTL and testbench
================================

WAH_SVF_SWEEP -- requirements
Module: wah_svf_sweep

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed audio sample width.
REQ-002 SHALL have parameter COEF_WIDTH, default 16: unsigned coefficient width, fixed-point with FRAC = COEF_WIDTH-2 fraction bits (1.0 = 2^FRAC).
REQ-003 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+4: signed filter state width.
REQ-004 Reset is decided: one clock; reset is synchronous and active-high.
REQ-005 Port clk  input  1  sole clock, rising edge.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port cs  input  1  block select.
REQ-008 Port my_turn  input  1  start request; a sample is accepted when cs=1 and my_turn=1 in IDLE.
REQ-009 Port data_in  input  DATA_WIDTH  signed input sample.
REQ-010 Port mode  input  2  output select: 0 LP, 1 BP, 2 HP, 3 notch (HP+LP).
REQ-011 Port bypass  input  1  pass input through; filter state held.
REQ-012 Port damping  input  COEF_WIDTH  q coefficient.
REQ-013 Port f_min, f_max, f_step  input  COEF_WIDTH each  sweep bounds and per-sample increment of f.
REQ-014 Port done  output  1  one-cycle pulse; data_out is valid.
REQ-015 Port data_out  output  DATA_WIDTH  registered signed result, held until the next done.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> CALC_YH -> CALC_YB -> CALC_YL -> SWEEP -> DONE -> IDLE, one cycle per state, except IDLE, which waits for a start.
REQ-018 On start, SHALL register data_in (sign-extended to ACC_WIDTH), mode and bypass; mid-sample changes to these inputs SHALL have no effect.
REQ-019 CALC_YH: yh = x - yl_prev - mul(damping, yb_prev).
REQ-020 CALC_YB: yb = mul(f, yh) + yb_prev.
REQ-021 CALC_YL: yl = mul(f, yb) + yl_prev.
REQ-022 mul(c,a) = (a * c) arithmetic-shifted right by FRAC (floor); c is treated as unsigned, and a single shared multiplier SHALL be used.
REQ-023 Every sum SHALL saturate to ACC_WIDTH signed range.
REQ-024 In DONE, SHALL copy yb and yl to yb_prev and yl_prev, and load data_out with the selected output saturated to DATA_WIDTH.
REQ-025 If bypass is captured as 1, data_out SHALL be the captured x; yb_prev and yl_prev SHALL remain unchanged; latency is unchanged.
REQ-026 SWEEP, direction up: if f+f_step >= f_max, then f=f_max and direction becomes down; otherwise f=f+f_step.
REQ-027 SWEEP, direction down: if f < f_min+f_step, then f=f_min and direction becomes up; otherwise f=f-f_step. Internal arithmetic SHALL be COEF_WIDTH+1 bits so that no wrap occurs.
REQ-028 If f_min >= f_max, SWEEP SHALL set f=f_min and direction up. If f_step=0, f SHALL be unchanged.
REQ-029 SWEEP SHALL run even when bypass=1; the new f SHALL apply from the next sample.
REQ-030 done SHALL be high exactly in DONE; with the start sampled at cycle T, done is high at T+5.
REQ-031 Starts arriving while busy SHALL be ignored, not queued; a held cs&my_turn SHALL restart only from IDLE, no earlier than T+6.

Reset
REQ-032 On rst=1 at any state, including mid-sample, SHALL:
- return the FSM to IDLE;
- clear done, busy, data_out, yb_prev, yl_prev and all intermediate values;
- load f from f_min with direction up.
REQ-033 After rst deasserts, SHALL accept a start in the first cycle.

Verification (DATA_WIDTH=16, COEF_WIDTH=16, ACC_WIDTH=20; 1.0=16384)
REQ-034 Setup f_min=f_max=8192, damping=16384, f_step=0, two samples x=1000. Required per mode:
- LP: 250, then 562.
- BP: 500, then 625.
- HP: 1000, then 250.
- done at T+5 each time.
REQ-035 Setup f=16384, damping=0, mode 3, after reset. Samples and required outputs:
- x=32767: yh=32767, yl=32767 -> data_out=32767 (65534 saturated).
- x=-32768: data_out=-32768 (saturated).
REQ-036 Setup f_min=100, f_max=130, f_step=20, bypass=1. Required f after successive samples: 120, 130, 110, 100, 120. Required data_out equals each data_in.
REQ-037 Assert rst during CALC_YB. Required: next cycle busy=0, data_out=0; a following x=1000 (LP, setup of REQ-034) gives 250.
REQ-038 Hold cs=my_turn=1 continuously. Required: done pulses exactly every 6 cycles; toggling mode mid-sample does not affect that sample's output.

Source files
------------

// File: rtl/wah_svf_sweep.sv
// Swept state-variable filter (wah): one sample per start, six-state sequence
// sharing a single multiplier, with a triangle sweep of the cutoff coefficient.
module wah_svf_sweep #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs,
  input  logic                         my_turn,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]                   mode,
  input  logic                         bypass,
  input  logic [COEF_WIDTH-1:0]        damping,
  input  logic [COEF_WIDTH-1:0]        f_min,
  input  logic [COEF_WIDTH-1:0]        f_max,
  input  logic [COEF_WIDTH-1:0]        f_step,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         busy
);

  localparam int FRAC = COEF_WIDTH - 2;
  localparam int PW   = ACC_WIDTH + COEF_WIDTH + 1;
  localparam int SW   = PW + 2;

  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] DAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] DAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CALC_YH, S_CALC_YB, S_CALC_YL, S_SWEEP, S_DONE
  } state_t;

  function automatic logic signed [SW-1:0] ext_acc(input logic signed [ACC_WIDTH-1:0] v);
    return {{(SW-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v > ACC_MAX) return ACC_MAX[ACC_WIDTH-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
    else return v[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [SW-1:0] v);
    if (v > DAT_MAX) return DAT_MAX[DATA_WIDTH-1:0];
    else if (v < DAT_MIN) return DAT_MIN[DATA_WIDTH-1:0];
    else return v[DATA_WIDTH-1:0];
  endfunction

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   x_q, x_d;
  logic [1:0]                    mode_q, mode_d;
  logic                          bypass_q, bypass_d;
  logic signed [ACC_WIDTH-1:0]   yh_q, yh_d;
  logic signed [ACC_WIDTH-1:0]   yb_q, yb_d;
  logic signed [ACC_WIDTH-1:0]   yl_q, yl_d;
  logic signed [ACC_WIDTH-1:0]   yb_prev_q, yb_prev_d;
  logic signed [ACC_WIDTH-1:0]   yl_prev_q, yl_prev_d;
  logic [COEF_WIDTH-1:0]         f_q, f_d;
  logic                          dir_up_q, dir_up_d;
  logic signed [DATA_WIDTH-1:0]  data_out_q, data_out_d;

  // Shared multiplier: coefficient is unsigned, so it gets a zero sign bit.
  logic signed [ACC_WIDTH-1:0]   mul_a;
  logic [COEF_WIDTH-1:0]         mul_c;
  logic signed [PW-1:0]          mul_a_ext, mul_c_ext, prod, mul_res;
  logic signed [SW-1:0]          mul_w;
  logic signed [SW-1:0]          out_sel;
  logic [COEF_WIDTH:0]           f_up, f_lo_lim;

  assign mul_a_ext = {{(PW-ACC_WIDTH){mul_a[ACC_WIDTH-1]}}, mul_a};
  assign mul_c_ext = {{(PW-COEF_WIDTH){1'b0}}, mul_c};
  assign prod      = mul_a_ext * mul_c_ext;
  assign mul_res   = prod >>> FRAC;
  assign mul_w     = {{(SW-PW){mul_res[PW-1]}}, mul_res};

  // One extra bit keeps the sweep comparisons free of wrap-around.
  assign f_up     = {1'b0, f_q} + {1'b0, f_step};
  assign f_lo_lim = {1'b0, f_min} + {1'b0, f_step};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    mode_d     = mode_q;
    bypass_d   = bypass_q;
    yh_d       = yh_q;
    yb_d       = yb_q;
    yl_d       = yl_q;
    yb_prev_d  = yb_prev_q;
    yl_prev_d  = yl_prev_q;
    f_d        = f_q;
    dir_up_d   = dir_up_q;
    data_out_d = data_out_q;
    mul_a      = yb_prev_q;
    mul_c      = damping;
    out_sel    = ext_acc(yl_q);

    case (state_q)
      S_IDLE: begin
        if (cs && my_turn) begin
          x_d      = {{(ACC_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
          mode_d   = mode;
          bypass_d = bypass;
          state_d  = S_CALC_YH;
        end
      end
      S_CALC_YH: begin
        mul_a   = yb_prev_q;
        mul_c   = damping;
        yh_d    = sat_acc(ext_acc(x_q) - ext_acc(yl_prev_q) - mul_w);
        state_d = S_CALC_YB;
      end
      S_CALC_YB: begin
        mul_a   = yh_q;
        mul_c   = f_q;
        yb_d    = sat_acc(mul_w + ext_acc(yb_prev_q));
        state_d = S_CALC_YL;
      end
      S_CALC_YL: begin
        mul_a   = yb_q;
        mul_c   = f_q;
        yl_d    = sat_acc(mul_w + ext_acc(yl_prev_q));
        state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (f_min >= f_max) begin
          f_d      = f_min;
          dir_up_d = 1'b1;
        end else if (f_step != '0) begin
          if (dir_up_q) begin
            if (f_up >= {1'b0, f_max}) begin
              f_d      = f_max;
              dir_up_d = 1'b0;
            end else begin
              f_d = f_up[COEF_WIDTH-1:0];
            end
          end else begin
            if ({1'b0, f_q} < f_lo_lim) begin
              f_d      = f_min;
              dir_up_d = 1'b1;
            end else begin
              f_d = f_q - f_step;
            end
          end
        end
        // Result and state commit land on the edge into DONE so they are
        // already valid while done is high.
        case (mode_q)
          2'd0:    out_sel = ext_acc(yl_q);
          2'd1:    out_sel = ext_acc(yb_q);
          2'd2:    out_sel = ext_acc(yh_q);
          default: out_sel = ext_acc(yh_q) + ext_acc(yl_q);
        endcase
        if (bypass_q) begin
          data_out_d = sat_data(ext_acc(x_q));
        end else begin
          data_out_d = sat_data(out_sel);
          yb_prev_d  = yb_q;
          yl_prev_d  = yl_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      mode_q     <= '0;
      bypass_q   <= 1'b0;
      yh_q       <= '0;
      yb_q       <= '0;
      yl_q       <= '0;
      yb_prev_q  <= '0;
      yl_prev_q  <= '0;
      f_q        <= f_min;
      dir_up_q   <= 1'b1;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      mode_q     <= mode_d;
      bypass_q   <= bypass_d;
      yh_q       <= yh_d;
      yb_q       <= yb_d;
      yl_q       <= yl_d;
      yb_prev_q  <= yb_prev_d;
      yl_prev_q  <= yl_prev_d;
      f_q        <= f_d;
      dir_up_q   <= dir_up_d;
      data_out_q <= data_out_d;
    end
  end

  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign data_out = data_out_q;

endmodule

// File: tb/tb_wah_svf_sweep.sv
// Bench for wah_svf_sweep: fixed vector table, hand-written corner sequences
// and randomized samples against an integer reference model.
module tb_wah_svf_sweep;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 20;
  localparam int FRAC = CW - 2;

  logic                 clk = 1'b0;
  logic                 rst, cs, my_turn, bypass;
  logic signed [DW-1:0] data_in;
  logic [1:0]           mode;
  logic [CW-1:0]        damping, f_min, f_max, f_step;
  logic                 done, busy;
  logic signed [DW-1:0] data_out;

  always #5 clk = ~clk;

  wah_svf_sweep #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .data_in(data_in),
    .mode(mode), .bypass(bypass), .damping(damping), .f_min(f_min),
    .f_max(f_max), .f_step(f_step), .done(done), .data_out(data_out), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the filter equations.
  longint m_yb, m_yl, m_f;
  bit     m_up;

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint mmul(input longint c, input longint a);
    return (a * c) >>> FRAC;
  endfunction

  task automatic model_reset();
    m_yb = 0;
    m_yl = 0;
    m_f  = longint'(f_min);
    m_up = 1'b1;
  endtask

  task automatic model_sample(input longint x, input int md, input bit byp, output longint out);
    longint yh, yb, yl, fmn, fmx, stp;
    yh = clamp(x - m_yl - mmul(longint'(damping), m_yb), AW);
    yb = clamp(mmul(m_f, yh) + m_yb, AW);
    yl = clamp(mmul(m_f, yb) + m_yl, AW);
    case (md)
      0:       out = clamp(yl, DW);
      1:       out = clamp(yb, DW);
      2:       out = clamp(yh, DW);
      default: out = clamp(yh + yl, DW);
    endcase
    if (byp) begin
      out = x;
    end else begin
      m_yb = yb;
      m_yl = yl;
    end
    fmn = longint'(f_min);
    fmx = longint'(f_max);
    stp = longint'(f_step);
    if (fmn >= fmx) begin
      m_f  = fmn;
      m_up = 1'b1;
    end else if (stp != 0) begin
      if (m_up) begin
        if (m_f + stp >= fmx) begin m_f = fmx; m_up = 1'b0; end
        else m_f = m_f + stp;
      end else begin
        if (m_f < fmn + stp) begin m_f = fmn; m_up = 1'b1; end
        else m_f = m_f - stp;
      end
    end
  endtask

  // Tasks are entered and left just after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_sample(input int x, input int md, input bit byp, input bit scramble,
                            output longint got);
    int  guard;
    int  t0;
    int  lat;
    bit  seen;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("idle_wait", busy, 0);
    cs      = 1'b1;
    my_turn = 1'b1;
    data_in = 16'(x);
    mode    = 2'(md);
    bypass  = byp;
    t0      = cyc;
    @(posedge clk);
    #1;
    cs      = 1'b0;
    my_turn = 1'b0;
    if (scramble) begin
      data_in = 16'($urandom);
      mode    = 2'($urandom);
      bypass  = 1'($urandom);
    end
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_mid", busy, 1);
      if (done) begin
        seen = 1'b1;
        lat  = cyc - t0;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) check("latency", lat, 5);
    got = data_out;
    $display("sample x=%0d mode=%0d bypass=%0d -> data_out=%0d latency=%0d", x, md, byp, got, lat);
  endtask

  typedef struct {
    bit do_rst;
    int fmin;
    int fmax;
    int step;
    int damp;
    int md;
    int x;
    int exp;
  } vec_t;

  vec_t   tbl[8];
  int     exp_f[5];
  longint got, mexp;

  initial begin
    tbl[0] = '{1, 8192, 8192, 0, 16384, 0, 1000, 250};
    tbl[1] = '{0, 8192, 8192, 0, 16384, 0, 1000, 562};
    tbl[2] = '{1, 8192, 8192, 0, 16384, 1, 1000, 500};
    tbl[3] = '{0, 8192, 8192, 0, 16384, 1, 1000, 625};
    tbl[4] = '{1, 8192, 8192, 0, 16384, 2, 1000, 1000};
    tbl[5] = '{0, 8192, 8192, 0, 16384, 2, 1000, 250};
    tbl[6] = '{1, 16384, 16384, 0, 0, 3, 32767, 32767};
    tbl[7] = '{0, 16384, 16384, 0, 0, 3, -32768, -32768};
    exp_f  = '{120, 130, 110, 100, 120};

    rst = 1'b1; cs = 1'b0; my_turn = 1'b0; bypass = 1'b0; data_in = '0; mode = '0;
    damping = 16'd16384; f_min = 16'd8192; f_max = 16'd8192; f_step = '0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data_out", data_out, 0);
    rst = 1'b0;
    model_reset();

    // Fixed vectors: reference-point filter responses and saturation.
    for (int i = 0; i < 8; i++) begin
      f_min = 16'(tbl[i].fmin); f_max = 16'(tbl[i].fmax);
      f_step = 16'(tbl[i].step); damping = 16'(tbl[i].damp);
      if (tbl[i].do_rst) begin
        do_reset();
        model_reset();
      end
      run_sample(tbl[i].x, tbl[i].md, 1'b0, 1'b0, got);
      model_sample(tbl[i].x, tbl[i].md, 1'b0, mexp);
      check("table_out", got, tbl[i].exp);
      check("table_model", got, mexp);
    end

    // Sweep bounce with bypass: output is the input, f follows the triangle.
    f_min = 16'd100; f_max = 16'd130; f_step = 16'd20; damping = 16'd16384;
    do_reset();
    model_reset();
    for (int k = 0; k < 5; k++) begin
      logic signed [15:0] r;
      r = 16'($urandom);
      run_sample(int'(r), int'($urandom_range(0, 3)), 1'b1, 1'b0, got);
      model_sample(longint'(r), 0, 1'b1, mexp);
      check("bypass_out", got, longint'(r));
      check("bypass_f", longint'(dut.f_q), exp_f[k]);
    end

    // Reset while in CALC_YB, then an immediate start after release.
    f_min = 16'd8192; f_max = 16'd8192; f_step = '0; damping = 16'd16384;
    do_reset();
    model_reset();
    run_sample(1000, 0, 1'b0, 1'b0, got);
    model_sample(1000, 0, 1'b0, mexp);
    check("pre_rst_out", got, 250);
    while (busy) @(negedge clk);
    cs = 1'b1; my_turn = 1'b1; data_in = 16'sd1000; mode = 2'd0; bypass = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; my_turn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_sample(1000, 0, 1'b0, 1'b0, got);
    model_sample(1000, 0, 1'b0, mexp);
    check("post_rst_out", got, 250);

    // Held start: done every 6 cycles while mode changes every cycle.
    do_reset();
    model_reset();
    begin
      int t0, rel;
      cs = 1'b1; my_turn = 1'b1; data_in = 16'sd1000; bypass = 1'b0;
      t0 = cyc;
      mode = 2'(cyc % 4);
      for (int i = 0; i < 23; i++) begin
        @(negedge clk);
        rel = cyc - t0;
        check("held_done", done, ((rel % 6) == 5) ? 1 : 0);
        if (done) begin
          model_sample(1000, (cyc - 5) % 4, 1'b0, mexp);
          check("held_out", data_out, mexp);
          $display("held sample done at +%0d -> data_out=%0d", rel, data_out);
        end
        mode = 2'(cyc % 4);
      end
      cs = 1'b0; my_turn = 1'b0;
    end

    // Randomized samples with mid-sample input scrambling.
    for (int k = 0; k < 60; k++) begin
      logic signed [15:0] r;
      int md;
      bit byp;
      if (k % 12 == 0) begin
        while (busy) @(negedge clk);
        f_min   = 16'($urandom_range(0, 12000));
        f_max   = 16'($urandom_range(0, 16000));
        f_step  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
        damping = 16'($urandom_range(4096, 32768));
      end
      r   = 16'($urandom);
      md  = int'($urandom_range(0, 3));
      byp = ($urandom_range(0, 4) == 0);
      run_sample(int'(r), md, byp, 1'b1, got);
      model_sample(longint'(r), md, byp, mexp);
      check("rand_out", got, mexp);
      check("rand_f", longint'(dut.f_q), m_f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
